// File: rtl/des_key_scheduler_if.sv
// Key-in / subkey-out handshake bundle for the DES key-schedule controller.
interface des_key_scheduler_if;
    localparam int unsigned KEY_W    = 64;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUND_W  = 4;

    logic                key_valid;
    logic                key_ready;
    logic [KEY_W-1:0]    key_in;
    logic                decrypt;
    logic                abort;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [SUBKEY_W-1:0] subkey;
    logic [ROUND_W-1:0]  round;
    logic                done;

    // Key producer / subkey consumer side
    modport master (
        output key_valid, key_in, decrypt, abort, subkey_ready,
        input  key_ready, subkey_valid, subkey, round, done
    );

    // Key scheduler side
    modport slave (
        input  key_valid, key_in, decrypt, abort, subkey_ready,
        output key_ready, subkey_valid, subkey, round, done
    );
endinterface

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: latches one key, emits 16 PC-2 subkeys in
// encrypt (K1..K16) or decrypt (K16..K1) order, one per handshake beat.
module des_key_scheduler #(
    parameter bit DECRYPT_EN   = 1'b1,
    parameter bit BACKPRESSURE = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    des_key_scheduler_if.slave  bus
);
    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUND_W  = 4;

    // Tables use DES numbering: entry n selects input bit n, bit 1 = MSB.
    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1: 64-bit key to 56-bit C||D, parity bits dropped
    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CD_W); i++) begin
            r[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TAB[i])];
        end
        return r;
    endfunction

    // PC-2: 56-bit C||D to 48-bit subkey
    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(SUBKEY_W); i++) begin
            r[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
        return r;
    endfunction

    // Rotation amount for the given emitted round; decrypt round 0 is K16 = C0/D0
    function automatic logic [1:0] shift_amt(input logic [ROUND_W-1:0] r, input logic dec);
        if (dec && (r == 4'd0)) begin
            return 2'd0;
        end
        if ((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15)) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    // 28-bit ring rotate by 0, 1 or 2 positions
    function automatic logic [HALF_W-1:0] rotate(input logic [HALF_W-1:0] h,
                                                 input logic left,
                                                 input logic [1:0] amt);
        case (amt)
            2'd1:    return left ? {h[26:0], h[27]}    : {h[0], h[27:1]};
            2'd2:    return left ? {h[25:0], h[27:26]} : {h[1:0], h[27:2]};
            default: return h;
        endcase
    endfunction

    // Rotate C and D independently for the given emitted round
    function automatic logic [CD_W-1:0] rotate_cd(input logic [CD_W-1:0] cd,
                                                  input logic dec,
                                                  input logic [ROUND_W-1:0] r);
        logic [1:0] amt;
        amt = shift_amt(r, dec);
        return {rotate(cd[CD_W-1:HALF_W], !dec, amt), rotate(cd[HALF_W-1:0], !dec, amt)};
    endfunction

    state_t               state_q;
    logic [CD_W-1:0]      cd_q;
    logic                 dec_q;
    logic [ROUND_W-1:0]   round_q;
    logic [SUBKEY_W-1:0]  subkey_q;
    logic                 subkey_valid_q;
    logic                 key_ready_q;
    logic                 done_q;

    logic                 dec_in_c;
    logic                 ready_c;
    logic [CD_W-1:0]      cd_first_c;
    logic [CD_W-1:0]      cd_step_c;

    // Parameter-gated inputs and next C/D candidates
    always_comb begin
        dec_in_c   = DECRYPT_EN ? bus.decrypt : 1'b0;
        ready_c    = BACKPRESSURE ? bus.subkey_ready : 1'b1;
        cd_first_c = rotate_cd(pc1(bus.key_in), dec_in_c, 4'd0);
        cd_step_c  = rotate_cd(cd_q, dec_q, 4'(round_q + 4'd1));
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cd_q           <= '0;
            dec_q          <= 1'b0;
            round_q        <= '0;
            subkey_q       <= '0;
            subkey_valid_q <= 1'b0;
            key_ready_q    <= 1'b1;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.key_valid) begin
                        cd_q           <= cd_first_c;
                        subkey_q       <= pc2(cd_first_c);
                        dec_q          <= dec_in_c;
                        round_q        <= '0;
                        subkey_valid_q <= 1'b1;
                        key_ready_q    <= 1'b0;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        subkey_valid_q <= 1'b0;
                        key_ready_q    <= 1'b1;
                        state_q        <= IDLE;
                    end else if (ready_c) begin
                        if (round_q == 4'd15) begin
                            subkey_valid_q <= 1'b0;
                            key_ready_q    <= 1'b1;
                            done_q         <= 1'b1;
                            state_q        <= IDLE;
                        end else begin
                            cd_q     <= cd_step_c;
                            subkey_q <= pc2(cd_step_c);
                            round_q  <= 4'(round_q + 4'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_ready    = key_ready_q;
    assign bus.subkey_valid = subkey_valid_q;
    assign bus.subkey       = subkey_q;
    assign bus.round        = round_q;
    assign bus.done         = done_q;
endmodule
